// File: rtl/data_memory_pkg.sv
// Shared encodings for the data memory and the CPU decode stage:
// RV32 load/store funct3 values, FSM states and default sizing.
package data_memory_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_t;

    // Unknown funct3 codes fall through to a word access.
    function automatic access_size_t access_size(input logic [2:0] f3, input logic is_store);
        access_size_t size;
        size = SIZE_WORD;
        if (is_store) begin
            case (f3)
                F3_SB:   size = SIZE_BYTE;
                F3_SH:   size = SIZE_HALF;
                default: size = SIZE_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: size = SIZE_BYTE;
                F3_LH, F3_LHU: size = SIZE_HALF;
                default:       size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/data_memory_load_store_align.sv
// Lane logic: picks and extends the addressed byte/half for loads and
// merges store data into the existing word, flagging misaligned accesses.
module load_store_align
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] write_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word,
    output logic        misaligned
);

    access_size_t size;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;

    always_comb begin
        size       = access_size(funct3, is_store);
        lane_byte  = word[{byte_offset, 3'b000} +: 8];
        lane_half  = byte_offset[1] ? word[31:16] : word[15:0];
        misaligned = 1'b0;
        load_value = word;
        store_word = write_data;
        case (size)
            SIZE_BYTE: begin
                load_value = funct3[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                store_word = word;
                store_word[{byte_offset, 3'b000} +: 8] = write_data[7:0];
            end
            SIZE_HALF: begin
                misaligned = byte_offset[0];
                load_value = funct3[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
                store_word = word;
                store_word[{byte_offset[1], 4'b0000} +: 16] = write_data[15:0];
            end
            default: begin
                misaligned = |byte_offset;
            end
        endcase
        // A misaligned load returns zero rather than a partial lane.
        if (misaligned) begin
            load_value = '0;
        end
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory for the CPU memory stage: accepts one load/store,
// stalls the pipeline for 1+LATENCY cycles, then releases it for one DONE cycle.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic        misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t           state;
    state_t           next_state;
    logic [3:0]       count;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] req_index;
    logic [1:0]       req_offset;
    logic [2:0]       req_funct3;
    logic [31:0]      req_wdata;
    logic             req_store;
    logic             request;
    logic             access_edge;
    logic [31:0]      cur_word;
    logic [31:0]      load_value;
    logic [31:0]      store_word;
    logic             lane_misaligned;
    logic             addr_unused;

    assign request     = read | write;
    assign access_edge = (state == ACCESS) && (count == 4'd1);
    assign cur_word    = mem[req_index];
    // High address bits are dropped so accesses wrap around the array.
    assign addr_unused = ^address[31:IDX_W+2];

    load_store_align u_align (
        .word        (cur_word),
        .byte_offset (req_offset),
        .funct3      (req_funct3),
        .is_store    (req_store),
        .write_data  (req_wdata),
        .load_value  (load_value),
        .store_word  (store_word),
        .misaligned  (lane_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE:    if (request) count <= 4'(LATENCY);
                ACCESS:  count <= count - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = ACCESS;
            ACCESS:  if (count == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busywait = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    busywait = request;
                ACCESS:  busywait = 1'b1;
                default: busywait = 1'b0;
            endcase
        end
    end

    // Request capture, array update and load result; reset wins over the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            readdata   <= '0;
            misaligned <= 1'b0;
            req_index  <= '0;
            req_offset <= '0;
            req_funct3 <= '0;
            req_wdata  <= '0;
            req_store  <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            if (state == IDLE && request) begin
                req_index  <= address[IDX_W+1:2];
                req_offset <= address[1:0];
                req_funct3 <= funct3;
                req_wdata  <= writedata;
                req_store  <= write;
            end
            if (access_edge) begin
                misaligned <= lane_misaligned;
                if (req_store) begin
                    if (!lane_misaligned) begin
                        mem[req_index] <= store_word;
                    end
                end else begin
                    readdata <= load_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a vector table of loads/stores with
// hand-computed results, plus reset-abort and back-to-back load sequences.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[20];

    data_memory #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .funct3     (funct3),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .busywait   (busywait),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drives one request at a falling edge and counts busy cycles; returns in DONE.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic hold, input string name, output int cycles);
        @(negedge clk);
        checkOutput({name, "_mis_idle"}, {31'b0, misaligned}, 32'h0);
        read      = rd;
        write     = wr;
        funct3    = f3;
        address   = addr;
        writedata = wdata;
        #1;
        cycles = 0;
        while (busywait && cycles < 40) begin
            cycles++;
            @(negedge clk);
            if (!hold) begin
                read  = 1'b0;
                write = 1'b0;
            end
            #1;
        end
        checkOutput({name, "_busy_cycles"}, 32'(cycles), 32'd3);
    endtask

    initial begin
        int cycles;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'h11223344, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h13,  32'h00000080, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'h80223344, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h11,  32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'h80223344, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h12,  32'h12345678, 32'h80223344, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'h80223344, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h20,  32'h00000005, 32'h80223344, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h420, 32'h0,        32'h00000005, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b101, 32'h12,  32'h0,        32'h00008022, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8022, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h11,  32'h0,        32'h00000033, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'b001, 32'h22,  32'h0000ABCD, 32'h00000033, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        32'hABCD0005, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'b011, 32'h20,  32'h0,        32'hABCD0005, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h22,  32'h0,        32'h00000000, 1'b1};

        reset     = 1'b1;
        read      = 1'b1;
        write     = 1'b0;
        funct3    = 3'b010;
        address   = 32'h0;
        writedata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busywait", {31'b0, busywait}, 32'h0);
        checkOutput("reset_readdata", readdata, 32'h0);
        checkOutput("reset_misaligned", {31'b0, misaligned}, 32'h0);
        reset = 1'b0;
        read  = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          1'b0, $sformatf("vec%0d", i), cycles);
            checkOutput($sformatf("vec%0d_done_busy", i), {31'b0, busywait}, 32'h0);
            checkOutput($sformatf("vec%0d_rdata", i), readdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_mis", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
        end

        // Reset lands on the access edge of a store: it must abort cleanly.
        @(negedge clk);
        write     = 1'b1;
        funct3    = 3'b010;
        address   = 32'h30;
        writedata = 32'hAAAA5555;
        @(negedge clk);
        write = 1'b0;
        #1;
        checkOutput("abort_busy_access1", {31'b0, busywait}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy_forced", {31'b0, busywait}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        checkOutput("abort_idle_busy", {31'b0, busywait}, 32'h0);
        checkOutput("abort_rdata_clr", readdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, "abort_lw", cycles);
        checkOutput("abort_lw_rdata", readdata, 32'h0);

        // READ held across two loads: DONE ignores it, next IDLE re-accepts.
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'h0BADF00D, 1'b0, "b2b_sw", cycles);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, "b2b_lw0", cycles);
        checkOutput("b2b_gap_low", {31'b0, busywait}, 32'h0);
        checkOutput("b2b_rdata0", readdata, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, "b2b_lw1", cycles);
        checkOutput("b2b_gap_low1", {31'b0, busywait}, 32'h0);
        checkOutput("b2b_rdata1", readdata, 32'h0BADF00D);
        read = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("b2b_idle_after", {31'b0, busywait}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
